// File: rtl/bcd_display_mux.sv
// bcd_display_mux: four-digit multiplexed common-anode seven-segment driver.
// Captures a packed BCD value on load, then scans one digit at a time through
// the display. Leading zeros can be blanked.
//
// Ports:
//   clk   in   1   system clock, rising edge
//   rst   in   1   synchronous active-high reset
//   bcd   in  16   packed BCD {thousands, hundreds, tens, units}
//   load  in   1   capture strobe for bcd into the shadow register
//   an    out  4   digit enables, active-low, an[0] = units digit
//   seg   out  7   segments, active-low, {g,f,e,d,c,b,a}
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [15:0]   val;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          tick;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          nz1, nz2, nz3;
  logic          blank;

  assign tick = (cnt == CNT_LAST);

  // Shadow register, prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= 16'h0000;
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      if (load) begin
        val <= bcd;
      end
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Nibble select for the active digit
  always_comb begin
    nib = val[3:0];
    case (idx)
      2'd0: nib = val[3:0];
      2'd1: nib = val[7:4];
      2'd2: nib = val[11:8];
      2'd3: nib = val[15:12];
      default: nib = val[3:0];
    endcase
  end

  // BCD to active-low gfedcba; invalid nibbles show a centre dash
  always_comb begin
    seg_dec = SEG_DASH;
    case (nib)
      4'd0: seg_dec = 7'b1000000;
      4'd1: seg_dec = 7'b1111001;
      4'd2: seg_dec = 7'b0100100;
      4'd3: seg_dec = 7'b0110000;
      4'd4: seg_dec = 7'b0011001;
      4'd5: seg_dec = 7'b0010010;
      4'd6: seg_dec = 7'b0000010;
      4'd7: seg_dec = 7'b1111000;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0010000;
      default: seg_dec = SEG_DASH;
    endcase
  end

  // nzK: some nibble from K up to 3 is non-zero (invalid codes count as non-zero)
  assign nz3 = (val[15:12] != 4'd0);
  assign nz2 = nz3 | (val[11:8] != 4'd0);
  assign nz1 = nz2 | (val[7:4] != 4'd0);

  // Digit 0 is never blanked so a zero value still shows one "0"
  always_comb begin
    blank = 1'b0;
    if (BLANK_LZ != 0) begin
      case (idx)
        2'd1: blank = ~nz1;
        2'd2: blank = ~nz2;
        2'd3: blank = ~nz3;
        default: blank = 1'b0;
      endcase
    end
  end

  // Registered outputs: an and seg always move on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (blank) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
module tb_bcd_display_mux;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] AB = 4'b1111;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        load;
  logic [3:0]  an_lz, an_nb;
  logic [6:0]  seg_lz, seg_nb;

  int vectors;
  int miscompares;

  bcd_display_mux #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .bcd(bcd), .load(load), .an(an_lz), .seg(seg_lz)
  );

  bcd_display_mux #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .bcd(bcd), .load(load), .an(an_nb), .seg(seg_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then compare both instances n times in a row
  task automatic slot(input string tag,
                      input logic [3:0] a_lz, input logic [6:0] s_lz,
                      input logic [3:0] a_nb, input logic [6:0] s_nb,
                      input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      assert ({an_lz, seg_lz} === {a_lz, s_lz}) else begin
        miscompares++;
        $error("FAIL %s[%0d] blank_lz: an=%b seg=%b expected an=%b seg=%b",
               tag, i, an_lz, seg_lz, a_lz, s_lz);
      end
      vectors++;
      assert ({an_nb, seg_nb} === {a_nb, s_nb}) else begin
        miscompares++;
        $error("FAIL %s[%0d] show_all: an=%b seg=%b expected an=%b seg=%b",
               tag, i, an_nb, seg_nb, a_nb, s_nb);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held with load asserted: load must be ignored
    rst  = 1'b1;
    load = 1'b1;
    bcd  = 16'h1234;
    slot("reset", AB, SB, AB, SB, 3);

    // Release; load 1234 on this first edge. Output still shows reset val=0
    rst = 1'b0;
    slot("post_reset", A0, S0, A0, S0, 1);
    load = 1'b0;

    // Remainder of digit-0 slot, then full frames of 1234
    slot("scan_d0a", A0, S4, A0, S4, 3);
    slot("scan_d1",  A1, S3, A1, S3, 4);
    slot("scan_d2",  A2, S2, A2, S2, 4);
    slot("scan_d3",  A3, S1, A3, S1, 4);
    slot("scan_d0",  A0, S4, A0, S4, 4);
    slot("scan2_d1", A1, S3, A1, S3, 4);
    slot("scan2_d2", A2, S2, A2, S2, 4);
    slot("scan2_d3", A3, S1, A3, S1, 4);
    slot("scan2_d0", A0, S4, A0, S4, 3);

    // Load 9999 on the tick edge of digit 0
    load = 1'b1;
    bcd  = 16'h9999;
    slot("tick_edge", A0, S4, A0, S4, 1);
    load = 1'b0;
    slot("tick_load_d1", A1, S9, A1, S9, 4);
    slot("nine_d2",      A2, S9, A2, S9, 4);
    slot("nine_d3",      A3, S9, A3, S9, 4);
    slot("nine_d0",      A0, S9, A0, S9, 3);

    // Load 0070 on the tick: leading-zero blanking
    load = 1'b1;
    bcd  = 16'h0070;
    slot("nine_d0_tick", A0, S9, A0, S9, 1);
    load = 1'b0;
    slot("lz_d1", A1, S7, A1, S7, 4);
    slot("lz_d2", AB, SB, A2, S0, 4);
    slot("lz_d3", AB, SB, A3, S0, 4);
    slot("lz_d0", A0, S0, A0, S0, 3);

    // Load 0000: only digit 0 lit when blanking
    load = 1'b1;
    bcd  = 16'h0000;
    slot("lz_d0_tick", A0, S0, A0, S0, 1);
    load = 1'b0;
    slot("zero_d1", AB, SB, A1, S0, 4);
    slot("zero_d2", AB, SB, A2, S0, 4);
    slot("zero_d3", AB, SB, A3, S0, 4);
    slot("zero_d0", A0, S0, A0, S0, 3);

    // Load 00A5: invalid tens nibble is a dash and counts as non-zero
    load = 1'b1;
    bcd  = 16'h00A5;
    slot("zero_d0_tick", A0, S0, A0, S0, 1);
    load = 1'b0;
    slot("err_d1",  A1, SD, A1, SD, 4);
    slot("err_d2",  AB, SB, A2, S0, 4);
    slot("err_d3",  AB, SB, A3, S0, 4);
    slot("err_d0",  A0, S5, A0, S5, 4);
    slot("err2_d1", A1, SD, A1, SD, 4);
    slot("err2_d2", AB, SB, A2, S0, 1);

    // Mid-frame reset while idx=2
    rst = 1'b1;
    slot("mid_reset", AB, SB, AB, SB, 1);
    rst = 1'b0;
    slot("restart_d0", A0, S0, A0, S0, 4);
    slot("restart_d1", AB, SB, A1, S0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
